// File: rtl/reservation_station.sv
// reservation_station: unified issue queue sitting after Rename.
// Holds renamed ops until both operands are present (captured at dispatch,
// via dispatch-time snoop, or from the wakeup broadcast), then issues the
// lowest-index ready op. Entries are freed on issue.
// Optional feature macro: RS_WAKEUP_ISSUE_BYPASS_EN -- lets an op issue in
// the same cycle its last operand appears on the wakeup bus.
module reservation_station #(
   parameter int DEPTH = 16,
   parameter int OP_W  = 8,
   parameter int TAG_W = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   dispatch_valid,
   output logic                   dispatch_ready,
   input  logic [OP_W-1:0]        dispatch_op,
   input  logic [31:0]            dispatch_imm,
   input  logic [TAG_W-1:0]       physical_rd,
   input  logic [TAG_W-1:0]       physical_rs1,
   input  logic [TAG_W-1:0]       physical_rs2,
   input  logic                   rs1_ready,
   input  logic                   rs2_ready,
   input  logic [31:0]            rs1_value,
   input  logic [31:0]            rs2_value,
   input  logic                   wakeup_active,
   input  logic [TAG_W-1:0]       wakeup_tag,
   input  logic [31:0]            wakeup_value,
   output logic                   issue_valid,
   input  logic                   issue_ready,
   output logic [OP_W-1:0]        issue_op,
   output logic [31:0]            issue_imm,
   output logic [TAG_W-1:0]       issue_rd,
   output logic [31:0]            issue_rs1_value,
   output logic [31:0]            issue_rs2_value,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int OCC_W = IDX_W + 1;

   // Control state (reset/flush cleared)
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [OCC_W-1:0] occ_q, occ_d;

   // Entry payload (qualified by valid_q, never reset)
   logic [DEPTH-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d;
   logic [OP_W-1:0]  op_q   [DEPTH];
   logic [OP_W-1:0]  op_d   [DEPTH];
   logic [31:0]      imm_q  [DEPTH];
   logic [31:0]      imm_d  [DEPTH];
   logic [TAG_W-1:0] rd_q   [DEPTH];
   logic [TAG_W-1:0] rd_d   [DEPTH];
   logic [TAG_W-1:0] tag1_q [DEPTH];
   logic [TAG_W-1:0] tag1_d [DEPTH];
   logic [TAG_W-1:0] tag2_q [DEPTH];
   logic [TAG_W-1:0] tag2_d [DEPTH];
   logic [31:0]      val1_q [DEPTH];
   logic [31:0]      val1_d [DEPTH];
   logic [31:0]      val2_q [DEPTH];
   logic [31:0]      val2_d [DEPTH];

   logic [DEPTH-1:0] wake1, wake2;
   logic [DEPTH-1:0] src1_ok, src2_ok, elig;
   logic [IDX_W-1:0] sel_idx, free_idx;
   logic             sel_found;
   logic             disp_fire, issue_fire;
   logic             snoop1, snoop2;

   // Per-entry match of a not-yet-ready source against the wakeup broadcast
   always_comb begin
      wake1 = '0;
      wake2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wake1[i] = wakeup_active && !rdy1_q[i] && (tag1_q[i] == wakeup_tag);
         wake2[i] = wakeup_active && !rdy2_q[i] && (tag2_q[i] == wakeup_tag);
      end
   end

`ifdef RS_WAKEUP_ISSUE_BYPASS_EN
   assign src1_ok = rdy1_q | wake1;
   assign src2_ok = rdy2_q | wake2;
`else
   assign src1_ok = rdy1_q;
   assign src2_ok = rdy2_q;
`endif

   assign elig = valid_q & src1_ok & src2_ok;

   // Lowest-index eligible entry is the issue candidate
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (elig[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   // Lowest-index free entry receives the next dispatch
   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) free_idx = IDX_W'(i);
      end
   end

   assign dispatch_ready = (occ_q != OCC_W'(DEPTH));
   assign disp_fire      = dispatch_valid && dispatch_ready;
   assign issue_valid    = sel_found;
   assign issue_fire     = sel_found && issue_ready;
   assign occupancy      = occ_q;

   // Catch a value completing in the same cycle Rename hands us the tag as not-ready
   assign snoop1 = wakeup_active && !rs1_ready && (physical_rs1 == wakeup_tag);
   assign snoop2 = wakeup_active && !rs2_ready && (physical_rs2 == wakeup_tag);

   // Issue outputs, forced to zero when nothing is selected
   always_comb begin
      issue_op        = '0;
      issue_imm       = '0;
      issue_rd        = '0;
      issue_rs1_value = '0;
      issue_rs2_value = '0;
      if (sel_found) begin
         issue_op  = op_q[sel_idx];
         issue_imm = imm_q[sel_idx];
         issue_rd  = rd_q[sel_idx];
`ifdef RS_WAKEUP_ISSUE_BYPASS_EN
         issue_rs1_value = rdy1_q[sel_idx] ? val1_q[sel_idx] : wakeup_value;
         issue_rs2_value = rdy2_q[sel_idx] ? val2_q[sel_idx] : wakeup_value;
`else
         issue_rs1_value = val1_q[sel_idx];
         issue_rs2_value = val2_q[sel_idx];
`endif
      end
   end

   // Next state: wakeup capture, issue release, dispatch write, occupancy
   always_comb begin
      valid_d = valid_q;
      rdy1_d  = rdy1_q;
      rdy2_d  = rdy2_q;
      op_d    = op_q;
      imm_d   = imm_q;
      rd_d    = rd_q;
      tag1_d  = tag1_q;
      tag2_d  = tag2_q;
      val1_d  = val1_q;
      val2_d  = val2_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && wake1[i]) begin
            rdy1_d[i] = 1'b1;
            val1_d[i] = wakeup_value;
         end
         if (valid_q[i] && wake2[i]) begin
            rdy2_d[i] = 1'b1;
            val2_d[i] = wakeup_value;
         end
      end

      if (issue_fire) valid_d[sel_idx] = 1'b0;

      // free_idx comes from valid_q, so a slot freed this cycle is not reused
      if (disp_fire) begin
         valid_d[free_idx] = 1'b1;
         op_d[free_idx]    = dispatch_op;
         imm_d[free_idx]   = dispatch_imm;
         rd_d[free_idx]    = physical_rd;
         tag1_d[free_idx]  = physical_rs1;
         tag2_d[free_idx]  = physical_rs2;
         rdy1_d[free_idx]  = rs1_ready || snoop1;
         rdy2_d[free_idx]  = rs2_ready || snoop2;
         val1_d[free_idx]  = rs1_ready ? rs1_value : wakeup_value;
         val2_d[free_idx]  = rs2_ready ? rs2_value : wakeup_value;
      end

      occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(issue_fire);
   end

   // Control registers: reset dominates flush, flush drops all traffic
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         occ_q   <= '0;
      end else if (flush) begin
         valid_q <= '0;
         occ_q   <= '0;
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
      end
   end

   // Payload registers: always loaded, meaningful only under valid_q
   always_ff @(posedge clk) begin
      rdy1_q <= rdy1_d;
      rdy2_q <= rdy2_d;
      op_q   <= op_d;
      imm_q  <= imm_d;
      rd_q   <= rd_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      val1_q <= val1_d;
      val2_q <= val2_d;
   end

endmodule

// File: tb/tb_reservation_station.sv
// Testbench for reservation_station: directed stimulus with an in-order
// scoreboard of expected issues, plus direct checks of status outputs.
module tb_reservation_station;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        dispatch_valid, dispatch_ready;
   logic [7:0]  dispatch_op;
   logic [31:0] dispatch_imm;
   logic [5:0]  physical_rd, physical_rs1, physical_rs2;
   logic        rs1_ready, rs2_ready;
   logic [31:0] rs1_value, rs2_value;
   logic        wakeup_active;
   logic [5:0]  wakeup_tag;
   logic [31:0] wakeup_value;
   logic        issue_valid, issue_ready;
   logic [7:0]  issue_op;
   logic [31:0] issue_imm;
   logic [5:0]  issue_rd;
   logic [31:0] issue_rs1_value, issue_rs2_value;
   logic [4:0]  occupancy;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] imm;
      logic [5:0]  rd;
      logic [31:0] v1;
      logic [31:0] v2;
   } exp_t;

   exp_t sb[$];

   reservation_station #(.DEPTH(16), .OP_W(8), .TAG_W(6)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_op(dispatch_op), .dispatch_imm(dispatch_imm),
      .physical_rd(physical_rd), .physical_rs1(physical_rs1), .physical_rs2(physical_rs2),
      .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
      .rs1_value(rs1_value), .rs2_value(rs2_value),
      .wakeup_active(wakeup_active), .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_op(issue_op), .issue_imm(issue_imm), .issue_rd(issue_rd),
      .issue_rs1_value(issue_rs1_value), .issue_rs2_value(issue_rs2_value),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_disp(input logic [7:0] op, input logic [31:0] imm, input logic [5:0] rd,
                           input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                           input logic [5:0] t2, input logic r2, input logic [31:0] v2);
      dispatch_valid = 1'b1;
      dispatch_op    = op;
      dispatch_imm   = imm;
      physical_rd    = rd;
      physical_rs1   = t1;
      rs1_ready      = r1;
      rs1_value      = v1;
      physical_rs2   = t2;
      rs2_ready      = r2;
      rs2_value      = v2;
   endtask

   // Scoreboard: every accepted issue must match the oldest expected record
   always @(negedge clk) begin
      exp_t e;
      if (!reset && !flush && issue_valid && issue_ready) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_issue", 32'(issue_rd), 32'h3f);
         end else begin
            e = sb.pop_front();
            check("sb_rd",  32'(issue_rd),  32'(e.rd));
            check("sb_op",  32'(issue_op),  32'(e.op));
            check("sb_imm", issue_imm,       e.imm);
            check("sb_v1",  issue_rs1_value, e.v1);
            check("sb_v2",  issue_rs2_value, e.v2);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; issue_ready = 1'b0;
      wakeup_active = 1'b0; wakeup_tag = '0; wakeup_value = '0;
      set_disp(8'h0, 32'h0, 6'd0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0);
      dispatch_valid = 1'b0;
      tick; tick;
      reset = 1'b0;
      @(negedge clk);
      check("rst_occ",    32'(occupancy), 0);
      check("rst_dready", 32'(dispatch_ready), 1);
      check("rst_ivalid", 32'(issue_valid), 0);
      check("rst_ird",    32'(issue_rd), 0);
      check("rst_iv1",    issue_rs1_value, 0);

      // Simple ready op, issued the cycle after dispatch
      tick;
      set_disp(8'h11, 32'd100, 6'd5, 6'd0, 1'b1, 32'd0, 6'd3, 1'b1, 32'd7);
      sb.push_back('{8'h11, 32'd100, 6'd5, 32'd0, 32'd7});
      tick;
      dispatch_valid = 1'b0;
      issue_ready = 1'b1;
      @(negedge clk);
      check("t1_ivalid", 32'(issue_valid), 1);
      check("t1_ird",    32'(issue_rd), 5);
      check("t1_iv2",    issue_rs2_value, 7);
      tick;
      issue_ready = 1'b0;
      @(negedge clk);
      check("t1_occ", 32'(occupancy), 0);

      // Wait on tag 9, then wake it
      tick;
      set_disp(8'h22, 32'd200, 6'd6, 6'd0, 1'b1, 32'd11, 6'd9, 1'b0, 32'hdead);
      sb.push_back('{8'h22, 32'd200, 6'd6, 32'd11, 32'd456});
      issue_ready = 1'b1;
      tick;
      dispatch_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t2_wait_ivalid", 32'(issue_valid), 0);
         tick;
      end
      wakeup_active = 1'b1; wakeup_tag = 6'd9; wakeup_value = 32'd456;
      @(negedge clk);
`ifdef RS_WAKEUP_ISSUE_BYPASS_EN
      check("t2_byp_ivalid", 32'(issue_valid), 1);
      check("t2_byp_iv2",    issue_rs2_value, 456);
`else
      check("t2_wk_ivalid", 32'(issue_valid), 0);
`endif
      tick;
      wakeup_active = 1'b0;
      @(negedge clk);
`ifdef RS_WAKEUP_ISSUE_BYPASS_EN
      check("t2_byp_after", 32'(issue_valid), 0);
`else
      check("t2_ivalid", 32'(issue_valid), 1);
      check("t2_iv2",    issue_rs2_value, 456);
`endif
      tick;
      @(negedge clk);
      check("t2_occ", 32'(occupancy), 0);

      // Dispatch-time snoop of a same-cycle wakeup
      tick;
      set_disp(8'h33, 32'd300, 6'd7, 6'd4, 1'b0, 32'hbad, 6'd0, 1'b1, 32'd2);
      wakeup_active = 1'b1; wakeup_tag = 6'd4; wakeup_value = 32'd123;
      sb.push_back('{8'h33, 32'd300, 6'd7, 32'd123, 32'd2});
      tick;
      dispatch_valid = 1'b0;
      wakeup_active = 1'b0;
      @(negedge clk);
      check("t3_ivalid", 32'(issue_valid), 1);
      check("t3_iv1",    issue_rs1_value, 123);
      tick;
      issue_ready = 1'b0;
      @(negedge clk);
      check("t3_occ", 32'(occupancy), 0);

      // Fill to DEPTH, drop the extra dispatch, then drain
      tick;
      for (int i = 0; i < 16; i++) begin
         set_disp(8'(i), 32'(1000 + i), 6'(16 + i), 6'd0, 1'b1, 32'(i), 6'd0, 1'b1, 32'(3 * i));
         sb.push_back('{8'(i), 32'(1000 + i), 6'(16 + i), 32'(i), 32'(3 * i)});
         tick;
      end
      set_disp(8'hee, 32'd9999, 6'd40, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
      tick;
      dispatch_valid = 1'b0;
      @(negedge clk);
      check("t4_full_occ",    32'(occupancy), 16);
      check("t4_full_dready", 32'(dispatch_ready), 0);
      check("t4_full_ird",    32'(issue_rd), 16);
      tick;
      issue_ready = 1'b1;
      tick;
      issue_ready = 1'b0;
      @(negedge clk);
      check("t4_occ15",    32'(occupancy), 15);
      check("t4_dready15", 32'(dispatch_ready), 1);
      check("t4_ird1",     32'(issue_rd), 17);
      tick;
      set_disp(8'h55, 32'd5555, 6'd50, 6'd0, 1'b1, 32'd50, 6'd0, 1'b1, 32'd51);
      issue_ready = 1'b1;
      sb.insert(1, '{8'h55, 32'd5555, 6'd50, 32'd50, 32'd51});
      tick;
      dispatch_valid = 1'b0;
      issue_ready = 1'b0;
      @(negedge clk);
      check("t4_both_occ", 32'(occupancy), 15);
      check("t4_new_ird",  32'(issue_rd), 50);
      tick;
      issue_ready = 1'b1;
      for (int k = 0; k < 40 && occupancy != 0; k++) tick;
      issue_ready = 1'b0;
      @(negedge clk);
      check("t4_drain_occ", 32'(occupancy), 0);
      check("t4_drain_sb",  32'(sb.size()), 0);

      // Two entries waiting on the same tag issue lowest index first
      tick;
      issue_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 2 || i == 5) begin
            set_disp(8'(64 + i), 32'(2000 + i), 6'(32 + i), 6'd8, 1'b0, 32'h0, 6'd0, 1'b1, 32'(200 + i));
            sb.push_back('{8'(64 + i), 32'(2000 + i), 6'(32 + i), 32'd77, 32'(200 + i)});
         end else begin
            set_disp(8'(64 + i), 32'(2000 + i), 6'(32 + i), 6'd20, 1'b0, 32'h0, 6'd0, 1'b1, 32'(200 + i));
         end
         tick;
      end
      dispatch_valid = 1'b0;
      @(negedge clk);
      check("t5_occ6",   32'(occupancy), 6);
      check("t5_ivalid", 32'(issue_valid), 0);
      tick;
      wakeup_active = 1'b1; wakeup_tag = 6'd8; wakeup_value = 32'd77;
      @(negedge clk);
`ifdef RS_WAKEUP_ISSUE_BYPASS_EN
      check("t5_first_ird", 32'(issue_rd), 34);
`else
      check("t5_wk_ivalid", 32'(issue_valid), 0);
`endif
      tick;
      wakeup_active = 1'b0;
      @(negedge clk);
`ifdef RS_WAKEUP_ISSUE_BYPASS_EN
      check("t5_second_ird", 32'(issue_rd), 37);
`else
      check("t5_first_ird", 32'(issue_rd), 34);
`endif
      tick;
      @(negedge clk);
`ifdef RS_WAKEUP_ISSUE_BYPASS_EN
      check("t5_idle", 32'(issue_valid), 0);
`else
      check("t5_second_ird", 32'(issue_rd), 37);
`endif
      tick;
      @(negedge clk);
      check("t5_occ4",    32'(occupancy), 4);
      check("t5_ivalid0", 32'(issue_valid), 0);

      // Flush with 4 stale entries and a concurrent dispatch
      tick;
      flush = 1'b1;
      set_disp(8'h77, 32'd7777, 6'd60, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2);
      tick;
      flush = 1'b0;
      dispatch_valid = 1'b0;
      @(negedge clk);
      check("t6_flush_occ",    32'(occupancy), 0);
      check("t6_flush_ivalid", 32'(issue_valid), 0);
      check("t6_flush_dready", 32'(dispatch_ready), 1);
      tick;
      wakeup_active = 1'b1; wakeup_tag = 6'd20; wakeup_value = 32'd1;
      tick;
      wakeup_active = 1'b0;
      @(negedge clk);
      check("t6_stale_ivalid", 32'(issue_valid), 0);

      // Reset in the middle of traffic
      tick;
      issue_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_disp(8'(i), 32'(i), 6'(10 + i), 6'd0, 1'b1, 32'(i), 6'd0, 1'b1, 32'(i));
         tick;
      end
      dispatch_valid = 1'b0;
      @(negedge clk);
      check("t7_pre_occ", 32'(occupancy), 3);
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      @(negedge clk);
      check("t7_rst_occ",    32'(occupancy), 0);
      check("t7_rst_ivalid", 32'(issue_valid), 0);
      check("t7_rst_ird",    32'(issue_rd), 0);
      check("t7_rst_dready", 32'(dispatch_ready), 1);

      check("end_sb_empty", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Unified issue queue directly downstream of Rename.
- Accepts one renamed op per cycle carrying physical tags, ready flags and operand values from Rename.
- Snoops the wakeup broadcast bus to capture missing operands.
- Issues one fully-ready op per cycle to the execute stage.
- Entries are freed on issue.

Parameters:
- DEPTH, 16, number of entries (power of two, 2..32)
- OP_W, 8, width of opaque opcode/control field
- TAG_W, 6, physical register tag width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- flush  in  1  synchronous clear of all entries (mispredict)
- dispatch_valid  in  1  renamed op present
- dispatch_ready  out  1  queue can accept (not full)
- dispatch_op  in  OP_W  opcode/control
- dispatch_imm  in  32  immediate
- physical_rd  in  TAG_W  destination tag
- physical_rs1  in  TAG_W  source 1 tag
- physical_rs2  in  TAG_W  source 2 tag
- rs1_ready  in  1  source 1 value valid
- rs2_ready  in  1  source 2 value valid
- rs1_value  in  32  source 1 value (meaningful when rs1_ready)
- rs2_value  in  32  source 2 value (meaningful when rs2_ready)
- wakeup_active  in  1  broadcast valid
- wakeup_tag  in  TAG_W  completing tag
- wakeup_value  in  32  completing value
- issue_valid  out  1  selected op ready to execute
- issue_ready  in  1  execute unit accepts
- issue_op  out  OP_W  selected opcode
- issue_imm  out  32  selected immediate
- issue_rd  out  TAG_W  selected destination tag
- issue_rs1_value  out  32  operand 1
- issue_rs2_value  out  32  operand 2
- occupancy  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset: all entries invalid.
  - occupancy=0, dispatch_ready=1, issue_valid=0.
  - issue_* data outputs are 0 while issue_valid=0.
- Entry state: valid, op, imm, rd, and per source {tag, ready, value}.
- Dispatch:
  - Fires when dispatch_valid && dispatch_ready.
  - Writes the lowest-index invalid entry at the edge.
  - dispatch_ready = (occupancy != DEPTH), combinational from registered state.
  - It does not account for a same-cycle issue. When full, dispatch stalls even if an issue fires that cycle.
- Dispatch snoop: if wakeup_active and wakeup_tag matches a not-ready dispatched source, the entry is written ready with wakeup_value.
  - This prevents a lost wakeup, since Rename may present the tag not-ready in the same cycle the value completes.
- Wakeup: every valid entry with a not-ready source whose tag == wakeup_tag captures wakeup_value and sets ready at the edge.
  - Both sources of one entry may match and are both captured.
- Select:
  - An entry is eligible when valid and both sources are ready.
  - The lowest-index eligible entry drives issue_*, combinationally from registered state.
  - issue_valid = any eligible.
- Issue: on issue_valid && issue_ready the selected entry is invalidated at the edge.
  - If issue_ready=0, the outputs hold the same entry unless a lower-index entry becomes eligible. Issue_* may switch while stalled; the consumer samples only on handshake.
- Simultaneous dispatch and issue in one cycle: occupancy unchanged.
  - The freed slot is not reused by that same cycle's dispatch.
- Ops with no source use tag 0 with ready=1 from Rename; no special-casing here.
- Priority: reset > flush > dispatch/issue/wakeup.
  - flush clears all valid bits at the edge. Dispatch and issue that cycle are discarded.
  - issue_valid is still driven combinationally during the flush cycle; the consumer must ignore it.
- Occupancy updates by +1 on dispatch, -1 on issue, both or neither gives 0, and never exceeds DEPTH.

Optional Feature:
- Macro: RS_WAKEUP_ISSUE_BYPASS_EN.
- Defined: eligibility also counts sources matching the current-cycle wakeup. issue_rsN_value muxes wakeup_value for the matching source, so an op can issue in the same cycle its last operand arrives.
- Undefined: a woken entry first becomes eligible the cycle after the wakeup.

Test Plan:
- Reset, then dispatch rd=5, rs1 tag 0 ready val 0, rs2 tag 3 ready val 7 -> next cycle issue_valid=1, issue_rd=5, issue_rs2_value=7; with issue_ready=1, occupancy returns to 0.
- Dispatch rd=6 with rs2 tag 9 not ready; hold 3 cycles -> issue_valid=0. Then wakeup tag 9 val 456 -> issue_valid=1, issue_rs2_value=456: next cycle without bypass, same cycle with bypass.
- Dispatch with rs1 tag 4 not ready in the same cycle as wakeup tag 4 val 123 -> entry stored ready and issues with issue_rs1_value=123 (no lost wakeup).
- Fill DEPTH=16 entries with ready ops while issue_ready=0 -> occupancy=16, dispatch_ready=0, and a 17th dispatch is dropped. Then issue_ready=1 for one cycle -> entry 0 issues, occupancy=15, dispatch_ready=1.
- Entries 2 and 5 both waiting on tag 8 -> wakeup tag 8 -> entry 2 issues first, entry 5 issues the next cycle.
- Assert flush with 4 entries valid alongside a dispatch -> next cycle occupancy=0, issue_valid=0. Assert reset mid-stream -> same result.
